// File: rtl/ks_memory_responder.sv
// Word-addressed memory responder for the K&S bus: captured request, WAIT_STATES delay, one-cycle ack.
// Optional bus-write protection of the low PROT_WORDS words is enabled by defining KS_MEM_WP_EN.
module ks_memory_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int PROT_WORDS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef KS_MEM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif
  localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W + 1)'(PROT_WORDS);
  localparam logic [2:0]      WS       = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              capture;
  logic              access;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wdata;
  logic              prot_hit;
  logic              mem_wr;
  logic              init_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  // With zero wait states the access happens at the sample edge, so it uses the live bus inputs.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            access    = 1'b1;
            acc_addr  = addr;
            acc_we    = we;
            acc_wdata = wdata;
            state_nx  = ST_ACK;
          end else begin
            cnt_nx   = WS;
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) begin
          access   = 1'b1;
          state_nx = ST_ACK;
        end
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign prot_hit = WP_EN && ({1'b0, acc_addr} < PROT_LIM);
  assign mem_wr   = rst_n & access & acc_we & ~prot_hit;
  assign init_wr  = rst_n & (state == ST_IDLE) & ~req & init_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (access && !acc_we) rdata <= mem[acc_addr];
      ack  <= access;
      busy <= (state_nx != ST_IDLE);
      err  <= access & acc_we & prot_hit;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr)       mem[acc_addr]  <= acc_wdata;
    else if (init_wr) mem[init_addr] <= init_data;
  end

endmodule

// File: tb/tb_ks_memory_responder.sv
// Self-checking bench for ks_memory_responder: vector table, directed corner sequences, random traffic vs a memory model.
module tb_ks_memory_responder;

  localparam int WS = 1;
`ifdef KS_MEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, init_we = 1'b0;
  logic [4:0]  addr = '0, init_addr = '0;
  logic [15:0] wdata = '0, init_data = '0;
  logic [15:0] rdata;
  logic        ack, busy, err;

  logic        req_z = 1'b0, we_z = 1'b0, init_we_z = 1'b0;
  logic [4:0]  addr_z = '0, init_addr_z = '0;
  logic [15:0] wdata_z = '0, init_data_z = '0;
  logic [15:0] rdata_z;
  logic        ack_z, busy_z, err_z;

  always #5 clk = ~clk;

  ks_memory_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_STATES(WS), .PROT_WORDS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  ks_memory_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_STATES(0), .PROT_WORDS(16)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
    .rdata(rdata_z), .ack(ack_z), .busy(busy_z), .err(err_z),
    .init_we(init_we_z), .init_addr(init_addr_z), .init_data(init_data_z)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] model_mem [32];
  logic [15:0] model_rd = '0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge with req low and the DUT idle.
  task automatic bd_write(input logic [4:0] a, input logic [15:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
    model_mem[a] = d;
  endtask

  // One bus transaction; noise drives a backdoor write that must be ignored throughout.
  task automatic do_txn(input logic t_we, input logic [4:0] t_addr, input logic [15:0] t_wdata,
                        input logic noise, input logic [4:0] n_addr, input logic [15:0] n_data);
    logic exp_err;
    int lat;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    if (noise) begin init_we = 1'b1; init_addr = n_addr; init_data = n_data; end
    @(posedge clk); #1;
    we = 1'($urandom); addr = 5'($urandom); wdata = 16'($urandom);
    exp_err = WP && t_we && (t_addr < 5'd16);
    if (!t_we)         model_rd = model_mem[t_addr];
    else if (!exp_err) model_mem[t_addr] = t_wdata;
    lat = 0;
    for (int j = 1; j <= WS + 4 && lat == 0; j++) begin
      @(negedge clk);
      check("busy_during_txn", 32'(busy), 32'd1);
      if (ack) begin
        lat = j;
        req = 1'b0; init_we = 1'b0;
        check("rdata_at_ack", 32'(rdata), 32'(model_rd));
        check("err_at_ack", 32'(err), 32'(exp_err));
      end
    end
    req = 1'b0; init_we = 1'b0;
    check("ack_latency", 32'(lat), 32'(WS + 1));
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("busy_falls", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;
    vecs[0] = '{1'b1, 5'd20, 16'hA5A5, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 5'd20, 16'h0000, 16'hA5A5, 1'b0};
    vecs[2] = '{1'b0, 5'd5,  16'h0000, 16'h1234, 1'b0};
    vecs[3] = '{1'b1, 5'd4,  16'hDEAD, 16'h0000, WP};
    vecs[4] = '{1'b0, 5'd4,  16'h0000, WP ? 16'h0444 : 16'hDEAD, 1'b0};
    vecs[5] = '{1'b1, 5'd16, 16'hCAFE, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 5'd16, 16'h0000, 16'hCAFE, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  16'h0000, 16'h0001, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ws0_busy", 32'(busy_z), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) bd_write(5'(i), 16'($urandom));
    bd_write(5'd0, 16'h0001);
    bd_write(5'd1, 16'h0002);
    bd_write(5'd3, 16'h0333);
    bd_write(5'd4, 16'h0444);
    bd_write(5'd5, 16'h1234);
    bd_write(5'd7, 16'h0777);

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 5'd0, 16'd0);
      if (vecs[i].we) check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      else            check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
    end

    // Back-to-back reads with req held high; addr changes after capture are ignored.
    req = 1'b1; we = 1'b0; addr = 5'd0;
    @(posedge clk); #1;
    addr = 5'd1;
    acks = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 1) begin
          check("b2b_first_lat", 32'(j), 32'(WS + 1));
          check("b2b_first_rdata", 32'(rdata), 32'h0001);
        end else begin
          check("b2b_second_lat", 32'(j), 32'(2 * WS + 3));
          check("b2b_second_rdata", 32'(rdata), 32'h0002);
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check("b2b_ack_count", 32'(acks), 32'd2);
    model_rd = 16'h0002;
    @(posedge clk); #1;

    do_txn(1'b0, 5'd10, 16'd0, 1'b1, 5'd7, 16'h9999);
    do_txn(1'b0, 5'd7, 16'd0, 1'b0, 5'd0, 16'd0);
    check("backdoor_collision", 32'(rdata), 32'h0777);

    // Reset in the middle of the wait state of a write.
    req = 1'b1; we = 1'b1; addr = 5'd3; wdata = 16'hBEEF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("midreset_ack", 32'(ack), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rd = '0;
    @(posedge clk); #1;
    do_txn(1'b0, 5'd3, 16'd0, 1'b0, 5'd0, 16'd0);
    check("midreset_write_discarded", 32'(rdata), 32'h0333);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) bd_write(5'($urandom), 16'($urandom));
      else do_txn(1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), 5'($urandom), 16'($urandom));
    end

    // Zero-wait instance: ack and data in the cycle right after the sample edge.
    init_we_z = 1'b1; init_addr_z = 5'd31; init_data_z = 16'h7FFF;
    @(posedge clk); #1;
    init_we_z = 1'b0;
    req_z = 1'b1; we_z = 1'b0; addr_z = 5'd31;
    @(posedge clk); #1;
    addr_z = 5'd0;
    @(negedge clk);
    check("ws0_ack", 32'(ack_z), 32'd1);
    check("ws0_rdata", 32'(rdata_z), 32'h7FFF);
    check("ws0_busy", 32'(busy_z), 32'd1);
    req_z = 1'b0;
    @(negedge clk);
    check("ws0_ack_drop", 32'(ack_z), 32'd0);
    check("ws0_busy_drop", 32'(busy_z), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
